// File: rtl/seq_bin2bcd_if.sv
// Start/busy/done handshake and result bus for seq_bin2bcd.
// SEQ_BIN2BCD_BLANK_EN adds the leading-zero blanking mask.
interface seq_bin2bcd_if #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
);
    logic                  i_start;
    logic [WIDTH-1:0]      i_binary;
    logic                  o_busy;
    logic                  o_done;
    logic [4*DIGITS-1:0]   o_bcd;
    logic                  o_ovf;
`ifdef SEQ_BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]     o_blank;

    modport master (output i_start, i_binary, input o_busy, o_done, o_bcd, o_ovf, o_blank);
    modport slave  (input i_start, i_binary, output o_busy, o_done, o_bcd, o_ovf, o_blank);
`else
    modport master (output i_start, i_binary, input o_busy, o_done, o_bcd, o_ovf);
    modport slave  (input i_start, i_binary, output o_busy, o_done, o_bcd, o_ovf);
`endif
endinterface

// File: rtl/seq_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// SEQ_BIN2BCD_BLANK_EN enables the registered leading-zero blanking mask.
//
// state   | meaning
// S_IDLE  | waiting for start, results held
// S_SHIFT | add-3 correction and shift, one binary bit per cycle
module seq_bin2bcd #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    seq_bin2bcd_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BCD_W-1:0] r_digits;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [BCD_W-1:0] r_bcd;
    logic             r_ovf;

    logic [BCD_W-1:0] w_corr;
    logic [BCD_W-1:0] w_next;
    logic             w_carry;

    // All digits corrected from their pre-correction values, then one shift.
    always_comb begin
        w_corr = r_digits;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digits[4*i +: 4] >= 4'd5)
                w_corr[4*i +: 4] = r_digits[4*i +: 4] + 4'd3;
        end
        w_carry = w_corr[BCD_W-1];
        w_next  = {w_corr[BCD_W-2:0], r_shift[WIDTH-1]};
    end

`ifdef SEQ_BIN2BCD_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank;
    logic              w_zero_above;

    always_comb begin
        w_blank      = '0;
        w_zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above & (w_next[4*i +: 4] == 4'd0);
            w_blank[i]   = w_zero_above;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_blank <= BLANK_RST;
        else if (r_state == S_SHIFT && r_cnt == CNT_W'(1))
            r_blank <= w_blank;
    end

    assign bus.o_blank = r_blank;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_digits <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_bcd    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_shift  <= bus.i_binary;
                        r_digits <= '0;
                        r_sticky <= 1'b0;
                        r_cnt    <= CNT_W'(WIDTH);
                        r_busy   <= 1'b1;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shift  <= r_shift << 1;
                    r_digits <= w_next;
                    r_sticky <= r_sticky | w_carry;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_bcd   <= w_next;
                        r_ovf   <= r_sticky | w_carry;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_bcd  = r_bcd;
    assign bus.o_ovf  = r_ovf;
endmodule

// File: tb/tb_seq_bin2bcd.sv
// Self-checking bench for seq_bin2bcd: a 3-digit and a 2-digit instance,
// directed scenarios plus random values against a decimal reference model.
module tb_seq_bin2bcd;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seq_bin2bcd_if #(.WIDTH(7), .DIGITS(3)) a ();
    seq_bin2bcd_if #(.WIDTH(7), .DIGITS(2)) b ();

    seq_bin2bcd #(.WIDTH(7), .DIGITS(3)) u_dut_a (.i_clk(clk), .i_rst(rst), .bus(a));
    seq_bin2bcd #(.WIDTH(7), .DIGITS(2)) u_dut_b (.i_clk(clk), .i_rst(rst), .bus(b));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pow10(input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] ref_bcd(input int v, input int d);
        logic [15:0] r = '0;
        int m = v % pow10(d);
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int v, input int d);
        return v >= pow10(d);
    endfunction

    function automatic logic [3:0] ref_blank(input int v, input int d);
        logic [3:0] r = '0;
        int m = v % pow10(d);
        for (int i = 1; i < d; i++) r[i] = (m < pow10(i));
        return r;
    endfunction

    task automatic run_a(input logic [6:0] v, output int cyc, output int busy_bad);
        a.i_binary = v;
        a.i_start  = 1'b1;
        step();
        a.i_start  = 1'b0;
        cyc = 0;
        busy_bad = 0;
        while (cyc < 40) begin
            if (a.o_done) break;
            if (a.o_busy !== 1'b1) busy_bad++;
            step();
            cyc++;
        end
    endtask

    task automatic run_b(input logic [6:0] v, output int cyc);
        b.i_binary = v;
        b.i_start  = 1'b1;
        step();
        b.i_start  = 1'b0;
        cyc = 0;
        while (cyc < 40) begin
            if (b.o_done) break;
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if ({a.o_busy, a.o_done, a.o_ovf, a.o_bcd} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_a busy/done/ovf/bcd got %b %b %b %h want 0 0 0 000",
                     a.o_busy, a.o_done, a.o_ovf, a.o_bcd);
        end
        n_checks++;
        if ({b.o_busy, b.o_done, b.o_ovf, b.o_bcd} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_b busy/done/ovf/bcd got %b %b %b %h want 0 0 0 00",
                     b.o_busy, b.o_done, b.o_ovf, b.o_bcd);
        end
`ifdef SEQ_BIN2BCD_BLANK_EN
        n_checks++;
        if (a.o_blank !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_blank got %b want 110", a.o_blank);
        end
`endif
    endtask

    task automatic test_latency();
        int cyc, busy_bad;
        run_a(7'd127, cyc, busy_bad);
        n_checks++;
        if (cyc != 7) begin
            n_fail++;
            $display("FAIL latency_127 got %0d cycles want 7", cyc);
        end
        n_checks++;
        if (busy_bad != 0 || a.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_127 got %0d low cycles, busy at done %b want 0 and 0", busy_bad, a.o_busy);
        end
        n_checks++;
        if (a.o_bcd !== 12'h127 || a.o_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL result_127 got %h ovf %b want 127 ovf 0", a.o_bcd, a.o_ovf);
        end
        step();
        n_checks++;
        if (a.o_done !== 1'b0 || a.o_bcd !== 12'h127) begin
            n_fail++;
            $display("FAIL done_width got done %b bcd %h want 0 127", a.o_done, a.o_bcd);
        end
    endtask

    task automatic test_small_values();
        int cyc, busy_bad;
        int vals [3] = '{0, 7, 105};
        logic [15:0] exp_bcd;
        logic [3:0]  exp_blank;
        foreach (vals[i]) begin
            run_a(7'(vals[i]), cyc, busy_bad);
            exp_bcd   = ref_bcd(vals[i], 3);
            exp_blank = ref_blank(vals[i], 3);
            n_checks++;
            if (cyc != 7 || a.o_bcd !== exp_bcd[11:0] || a.o_ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL small_%0d got cyc %0d bcd %h ovf %b want 7 %h 0",
                         vals[i], cyc, a.o_bcd, a.o_ovf, exp_bcd[11:0]);
            end
`ifdef SEQ_BIN2BCD_BLANK_EN
            n_checks++;
            if (a.o_blank !== exp_blank[2:0]) begin
                n_fail++;
                $display("FAIL blank_%0d got %b want %b", vals[i], a.o_blank, exp_blank[2:0]);
            end
`endif
            step();
        end
    endtask

    task automatic test_back_to_back();
        int cyc1 = 0;
        int cyc2 = 0;
        a.i_binary = 7'd99;
        a.i_start  = 1'b1;
        step();
        a.i_binary = 7'd100;
        while (cyc1 < 40 && a.o_done !== 1'b1) begin
            step();
            cyc1++;
        end
        n_checks++;
        if (cyc1 != 7 || a.o_bcd !== 12'h099) begin
            n_fail++;
            $display("FAIL b2b_first got cyc %0d bcd %h want 7 099", cyc1, a.o_bcd);
        end
        step();
        a.i_start = 1'b0;
        cyc2 = 1;
        n_checks++;
        if (a.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept got busy %b want 1", a.o_busy);
        end
        while (cyc2 < 40 && a.o_done !== 1'b1) begin
            step();
            cyc2++;
        end
        n_checks++;
        if (cyc2 != 8 || a.o_bcd !== 12'h100) begin
            n_fail++;
            $display("FAIL b2b_second got spacing %0d bcd %h want 8 100", cyc2, a.o_bcd);
        end
        step();
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        int cyc   = 0;
        a.i_binary = 7'd64;
        a.i_start  = 1'b1;
        step();
        a.i_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                a.i_binary = 7'd55;
                a.i_start  = 1'b1;
            end
            if (i == 4) a.i_start = 1'b0;
            if (a.o_done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    cyc = i;
                    n_checks++;
                    if (a.o_bcd !== 12'h064) begin
                        n_fail++;
                        $display("FAIL ignore_result got %h want 064", a.o_bcd);
                    end
                end
            end
            step();
        end
        n_checks++;
        if (dones != 1 || cyc != 7) begin
            n_fail++;
            $display("FAIL ignore_done got %0d pulses first at %0d want 1 at 7", dones, cyc);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        run_b(7'd127, cyc);
        n_checks++;
        if (cyc != 7 || b.o_bcd !== 8'h27 || b.o_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_127 got cyc %0d bcd %h ovf %b want 7 27 1", cyc, b.o_bcd, b.o_ovf);
        end
        step();
        run_b(7'd99, cyc);
        n_checks++;
        if (cyc != 7 || b.o_bcd !== 8'h99 || b.o_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_99 got cyc %0d bcd %h ovf %b want 7 99 0", cyc, b.o_bcd, b.o_ovf);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int cyc, busy_bad;
        a.i_binary = 7'd88;
        a.i_start  = 1'b1;
        step();
        a.i_start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({a.o_busy, a.o_done, a.o_ovf, a.o_bcd} !== 15'd0) begin
            n_fail++;
            $display("FAIL rst_mid busy/done/ovf/bcd got %b %b %b %h want 0 0 0 000",
                     a.o_busy, a.o_done, a.o_ovf, a.o_bcd);
        end
`ifdef SEQ_BIN2BCD_BLANK_EN
        n_checks++;
        if (a.o_blank !== 3'b110) begin
            n_fail++;
            $display("FAIL rst_mid_blank got %b want 110", a.o_blank);
        end
`endif
        for (int i = 0; i < 12; i++) begin
            if (a.o_done === 1'b1 || a.o_busy === 1'b1) dones++;
            step();
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet got %0d active cycles want 0", dones);
        end
        run_a(7'd88, cyc, busy_bad);
        n_checks++;
        if (cyc != 7 || a.o_bcd !== 12'h088 || a.o_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_redo got cyc %0d bcd %h ovf %b want 7 088 0", cyc, a.o_bcd, a.o_ovf);
        end
        step();
    endtask

    task automatic test_random();
        int v, cyc, busy_bad;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_blank;
        for (int n = 0; n < 30; n++) begin
            v = int'($urandom_range(0, 127));
            run_a(7'(v), cyc, busy_bad);
            exp_bcd   = ref_bcd(v, 3);
            exp_blank = ref_blank(v, 3);
            n_checks++;
            if (cyc != 7 || busy_bad != 0 || a.o_bcd !== exp_bcd[11:0] || a.o_ovf !== ref_ovf(v, 3)) begin
                n_fail++;
                $display("FAIL rand_a v=%0d got cyc %0d bcd %h ovf %b want 7 %h %b",
                         v, cyc, a.o_bcd, a.o_ovf, exp_bcd[11:0], ref_ovf(v, 3));
            end
`ifdef SEQ_BIN2BCD_BLANK_EN
            n_checks++;
            if (a.o_blank !== exp_blank[2:0]) begin
                n_fail++;
                $display("FAIL rand_blank v=%0d got %b want %b", v, a.o_blank, exp_blank[2:0]);
            end
`endif
            if (n % 2 == 0) step();

            v = int'($urandom_range(0, 127));
            run_b(7'(v), cyc);
            exp_bcd   = ref_bcd(v, 2);
            exp_blank = ref_blank(v, 2);
            n_checks++;
            if (cyc != 7 || b.o_bcd !== exp_bcd[7:0] || b.o_ovf !== ref_ovf(v, 2)) begin
                n_fail++;
                $display("FAIL rand_b v=%0d got cyc %0d bcd %h ovf %b want 7 %h %b",
                         v, cyc, b.o_bcd, b.o_ovf, exp_bcd[7:0], ref_ovf(v, 2));
            end
`ifdef SEQ_BIN2BCD_BLANK_EN
            n_checks++;
            if (b.o_blank !== exp_blank[1:0]) begin
                n_fail++;
                $display("FAIL rand_b_blank v=%0d got %b want %b", v, b.o_blank, exp_blank[1:0]);
            end
`endif
            step();
        end
    endtask

    initial begin
        a.i_start  = 1'b0;
        a.i_binary = '0;
        b.i_start  = 1'b0;
        b.i_binary = '0;
        test_reset();
        test_latency();
        test_small_values();
        test_back_to_back();
        test_ignore_start();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
